fir_mac_engine: RTL and testbench

Sequencing and multiply-accumulate stage of the FIR filter. It accepts one new input sample per handshake and pulses the shift register once to load it. It then walks `tap_index` through every tap, sending that index to the tap multiplexer and the coefficient store, and accumulates `tap_data × coef_data` into a full-precision sum. When the last tap is processed it emits one output sample `y_out` with a single-cycle valid pulse.

---
 rtl/fir_pkg.sv | 20 ++
 rtl/fir_mac_engine_mac_datapath.sv | 64 ++++++
 rtl/fir_mac_engine.sv | 83 ++++++++
 tb/tb_fir_mac_engine.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared types and helpers for the FIR filter datapath.
// Holds the sequencing state encoding and accumulator sizing.
package fir_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_MAC   = 2'd2
  } state_t;

  // Guard bits cover the growth from summing num_taps products.
  function automatic int acc_w(
    input int dw,
    input int cw,
    input int nt
  );
    return dw + cw + $clog2(nt);
  endfunction

endpackage

// File: rtl/fir_mac_engine_mac_datapath.sv
// Signed multiplier, sign extension, accumulator and output register
// for the FIR multiply-accumulate engine.
module mac_datapath
  import fir_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int COEF_WIDTH = 8,
  parameter int ACC_WIDTH  = 19
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_clr,
  input  logic                         i_en,
  input  logic                         i_last,
  input  logic signed [DATA_WIDTH-1:0] i_tap,
  input  logic signed [COEF_WIDTH-1:0] i_coef,
  output logic signed [ACC_WIDTH-1:0]  o_y,
  output logic                         o_y_valid
);

  localparam int PW = DATA_WIDTH + COEF_WIDTH;

  logic signed [PW-1:0]        w_tap_ext;
  logic signed [PW-1:0]        w_coef_ext;
  logic signed [PW-1:0]        w_prod;
  logic signed [ACC_WIDTH-1:0] w_prod_ext;
  logic signed [ACC_WIDTH-1:0] w_sum;
  logic signed [ACC_WIDTH-1:0] r_acc;
  logic signed [ACC_WIDTH-1:0] r_y;
  logic                        r_y_valid;

  assign w_tap_ext  = {{COEF_WIDTH{i_tap[DATA_WIDTH-1]}}, i_tap};
  assign w_coef_ext = {{DATA_WIDTH{i_coef[COEF_WIDTH-1]}}, i_coef};
  assign w_prod     = w_tap_ext * w_coef_ext;
  assign w_prod_ext = {{(ACC_WIDTH-PW){w_prod[PW-1]}}, w_prod};
  assign w_sum      = r_acc + w_prod_ext;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_acc <= '0;
    end else if (i_clr) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= w_sum;
    end
  end

  // The final tap bypasses the accumulator so the result is ready one cycle sooner.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_y       <= '0;
      r_y_valid <= 1'b0;
    end else begin
      r_y_valid <= i_en && i_last;
      if (i_en && i_last) begin
        r_y <= w_sum;
      end
    end
  end

  assign o_y       = r_y;
  assign o_y_valid = r_y_valid;

endmodule

// File: rtl/fir_mac_engine.sv
// FIR sequencing stage: sample handshake, shift strobe, tap walk
// and multiply-accumulate into a full-precision output.
module fir_mac_engine
  import fir_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int COEF_WIDTH = 8,
  parameter int NUM_TAPS   = 8,
  parameter int ACC_WIDTH  = acc_w(DATA_WIDTH, COEF_WIDTH, NUM_TAPS)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          sample_valid,
  output logic                          sample_ready,
  output logic                          shift_en,
  output logic [$clog2(NUM_TAPS)-1:0]   tap_index,
  input  logic signed [DATA_WIDTH-1:0]  tap_data,
  input  logic signed [COEF_WIDTH-1:0]  coef_data,
  output logic signed [ACC_WIDTH-1:0]   y_out,
  output logic                          y_valid
);

  localparam int TW = $clog2(NUM_TAPS);
  localparam logic [TW-1:0] LAST_TAP = TW'(NUM_TAPS - 1);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [TW-1:0] r_tap;
  logic          r_alive;
  logic          w_mac;
  logic          w_last;

  assign w_mac  = (r_state == ST_MAC);
  assign w_last = w_mac && (r_tap == LAST_TAP);

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:  if (sample_valid && sample_ready) w_state_nxt = ST_SHIFT;
      ST_SHIFT: w_state_nxt = ST_MAC;
      ST_MAC:   if (w_last) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // r_alive holds off sample_ready until the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_tap   <= '0;
      r_alive <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_alive <= 1'b1;
      if (w_mac && !w_last) begin
        r_tap <= r_tap + 1'b1;
      end else begin
        r_tap <= '0;
      end
    end
  end

  assign sample_ready = r_alive && (r_state == ST_IDLE);
  assign shift_en     = (r_state == ST_SHIFT);
  assign tap_index    = r_tap;

  mac_datapath #(
    .DATA_WIDTH (DATA_WIDTH),
    .COEF_WIDTH (COEF_WIDTH),
    .ACC_WIDTH  (ACC_WIDTH)
  ) u_mac (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_clr     (shift_en),
    .i_en      (w_mac),
    .i_last    (w_last),
    .i_tap     (tap_data),
    .i_coef    (coef_data),
    .o_y       (y_out),
    .o_y_valid (y_valid)
  );

endmodule

// File: tb/tb_fir_mac_engine.sv
// Directed bench for fir_mac_engine with a behavioural tap mux
// and coefficient store.
module tb_fir_mac_engine;

  logic               clk;
  logic               rst_n;
  logic               sample_valid;
  logic               sample_ready;
  logic               shift_en;
  logic [2:0]         tap_index;
  logic signed [7:0]  tap_data;
  logic signed [7:0]  coef_data;
  logic signed [18:0] y_out;
  logic               y_valid;

  logic signed [7:0] taps  [8];
  logic signed [7:0] coefs [8];

  int checks;
  int errors;
  int shift_cnt;
  int yv_cnt;

  assign tap_data  = taps[tap_index];
  assign coef_data = coefs[tap_index];

  fir_mac_engine dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .shift_en     (shift_en),
    .tap_index    (tap_index),
    .tap_data     (tap_data),
    .coef_data    (coef_data),
    .y_out        (y_out),
    .y_valid      (y_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (shift_en) shift_cnt <= shift_cnt + 1;
    if (y_valid)  yv_cnt    <= yv_cnt + 1;
  end

  task automatic check(
    input string              tag,
    input logic signed [63:0] obs,
    input logic signed [63:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_all(input int t, input int c);
    for (int k = 0; k < 8; k++) begin
      taps[k]  = 8'(t);
      coefs[k] = 8'(c);
    end
  endtask

  // Handshake one sample; returns result and cycles from handshake to y_valid.
  task automatic run_sample(
    output logic signed [63:0] y,
    output int                 lat
  );
    int w;
    w = 0;
    while (!sample_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    check("ready_wait", sample_ready, 1);
    sample_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    sample_valid = 1'b0;
    lat = 1;
    while (!y_valid && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    y = y_out;
  endtask

  initial begin
    logic signed [63:0] y;
    logic signed [63:0] ref_sum;
    int lat;
    int hs;
    int sc0;
    int yv0;
    int w;
    int ready_mid;
    int yv_pos[$];

    checks       = 0;
    errors       = 0;
    shift_cnt    = 0;
    yv_cnt       = 0;
    sample_valid = 1'b0;
    rst_n        = 1'b0;
    set_all(0, 0);

    #1;
    check("rst_ready", sample_ready, 0);
    check("rst_shift", shift_en, 0);
    check("rst_tap", tap_index, 0);
    check("rst_yvalid", y_valid, 0);
    check("rst_yout", y_out, 0);

    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("ready_pre_edge", sample_ready, 0);
    @(posedge clk);
    #1;
    check("ready_post_edge", sample_ready, 1);

    // All ones: trace shift strobe and tap walk cycle by cycle.
    set_all(1, 1);
    @(negedge clk);
    sc0 = shift_cnt;
    sample_valid = 1'b1;
    @(posedge clk);
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (n == 1) sample_valid = 1'b0;
      check("shift_en_cyc", shift_en, (n == 1) ? 1 : 0);
      if (n >= 2 && n <= 9) check("tap_walk", tap_index, n - 2);
      if (n >= 1 && n <= 9) check("busy_ready", sample_ready, 0);
      check("yvalid_cyc", y_valid, (n == 10) ? 1 : 0);
    end
    check("ones_y", y_out, 8);
    check("ones_shift_cnt", shift_cnt - sc0, 1);
    check("ones_ready_back", sample_ready, 1);

    for (int k = 0; k < 8; k++) begin
      taps[k]  = 8'(k == 0 ? 1 : 0);
      coefs[k] = 8'(k + 1);
    end
    run_sample(y, lat);
    check("impulse0_lat", lat, 10);
    check("impulse0_y", y, 1);

    for (int k = 0; k < 8; k++) taps[k] = 8'(k == 7 ? 1 : 0);
    run_sample(y, lat);
    check("impulse7_y", y, 8);

    set_all(-128, -128);
    run_sample(y, lat);
    check("neg_neg_y", y, 131072);

    set_all(-128, 127);
    run_sample(y, lat);
    check("neg_pos_y", y, -130048);

    set_all(2, -3);
    run_sample(y, lat);
    check("mixed_y", y, -48);

    // Backpressure: valid held for 25 cycles.
    set_all(1, 1);
    @(negedge clk);
    sample_valid = 1'b1;
    hs = 0;
    ready_mid = 0;
    for (int i = 0; i < 45 && yv_pos.size() < 3; i++) begin
      if (i == 25) sample_valid = 1'b0;
      if (i < 25 && sample_ready) hs++;
      if (i == 5 || i == 15) ready_mid += int'(sample_ready);
      if (y_valid) begin
        yv_pos.push_back(i);
        check("bp_y", y_out, 8);
      end
      @(negedge clk);
    end
    sample_valid = 1'b0;
    check("bp_handshakes", hs, 3);
    check("bp_ready_low", ready_mid, 0);
    check("bp_pulses", yv_pos.size(), 3);
    if (yv_pos.size() == 3) begin
      check("bp_first", yv_pos[0], 10);
      check("bp_gap1", yv_pos[1] - yv_pos[0], 10);
      check("bp_gap2", yv_pos[2] - yv_pos[1], 10);
    end

    // Reset in the middle of the tap walk.
    set_all(5, 5);
    w = 0;
    while (!sample_ready && w < 30) begin
      @(negedge clk);
      w++;
    end
    sample_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    sample_valid = 1'b0;
    w = 0;
    while (tap_index != 3'd4 && w < 20) begin
      @(negedge clk);
      w++;
    end
    check("mid_tap_reached", tap_index, 4);
    yv0 = yv_cnt;
    rst_n = 1'b0;
    #1;
    check("mid_rst_tap", tap_index, 0);
    check("mid_rst_shift", shift_en, 0);
    check("mid_rst_yout", y_out, 0);
    check("mid_rst_yvalid", y_valid, 0);
    check("mid_rst_ready", sample_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) @(negedge clk);
    check("mid_no_yvalid", yv_cnt - yv0, 0);

    set_all(2, 3);
    run_sample(y, lat);
    check("post_rst_lat", lat, 10);
    check("post_rst_y", y, 48);

    // Randomised taps and coefficients against a reference sum.
    for (int s = 0; s < 100; s++) begin
      ref_sum = 0;
      for (int k = 0; k < 8; k++) begin
        taps[k]  = 8'($urandom);
        coefs[k] = 8'($urandom);
        ref_sum  = ref_sum + taps[k] * coefs[k];
      end
      run_sample(y, lat);
      check("rand_y", y, ref_sum);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
